// File: rtl/tlul_mem_responder.sv
// -----------------------------------------------------------------------------
// tlul_mem_responder
//
// TL-UL device-side responder backed by a flop-based word memory. A-channel
// requests are checked, executed against the memory at the accept edge, and
// their responses are pushed into an in-order response FIFO. The D channel
// is driven from the FIFO head, so the host may have up to RspDepth requests
// outstanding.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   a_valid_i           request valid
//   a_opcode_i          0=PutFullData, 1=PutPartialData, 4=Get
//   a_param_i           ignored
//   a_size_i            log2 of access size in bytes
//   a_source_i          request ID, echoed on d_source_o
//   a_address_i         byte address
//   a_mask_i            byte lane enables for Put
//   a_data_i            write data
//   a_ready_o           request accepted when a_valid_i & a_ready_o
//   d_valid_o           response valid (FIFO not empty)
//   d_opcode_o          0=AccessAck, 1=AccessAckData
//   d_param_o, d_sink_o always 0
//   d_size_o            echo of a_size_i
//   d_source_o          echo of a_source_i
//   d_data_o            read data, 0 for writes, all-ones for failed reads
//   d_error_o           error response
//   d_ready_i           response consumed when d_valid_o & d_ready_i
// -----------------------------------------------------------------------------
module tlul_mem_responder #(
    parameter int Depth    = 16,
    parameter int RspDepth = 2,
    parameter int SourceW  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               a_valid_i,
    input  logic [2:0]         a_opcode_i,
    input  logic [2:0]         a_param_i,
    input  logic [1:0]         a_size_i,
    input  logic [SourceW-1:0] a_source_i,
    input  logic [31:0]        a_address_i,
    input  logic [3:0]         a_mask_i,
    input  logic [31:0]        a_data_i,
    output logic               a_ready_o,

    output logic               d_valid_o,
    output logic [2:0]         d_opcode_o,
    output logic [2:0]         d_param_o,
    output logic [1:0]         d_size_o,
    output logic [SourceW-1:0] d_source_o,
    output logic               d_sink_o,
    output logic [31:0]        d_data_o,
    output logic               d_error_o,
    input  logic               d_ready_i
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);

    localparam logic [PtrW-1:0] PtrMax   = PtrW'(RspDepth - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(RspDepth);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef struct packed {
        logic [2:0]         opcode;
        logic [1:0]         size;
        logic [SourceW-1:0] source;
        logic [31:0]        data;
        logic               error;
    } rsp_t;

    logic [31:0]     mem_q  [Depth];
    logic [31:0]     mem_d  [Depth];
    rsp_t            fifo_q [RspDepth];
    rsp_t            fifo_d [RspDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [IdxW-1:0] idx;
    logic            is_get;
    logic            is_put;
    logic            align_ok;
    logic            range_ok;
    logic            req_err;
    rsp_t            rsp_new;
    rsp_t            head;

    // a_param_i carries no meaning for this device.
    logic unused_param;
    assign unused_param = ^a_param_i;

    // Ready depends only on registered occupancy (and reset), never on
    // d_ready_i, so a full FIFO refuses a request even in a pop cycle.
    assign a_ready_o = !rst_i && (count_q < CntFull);
    assign d_valid_o = (count_q != '0);

    assign push = a_valid_i && a_ready_o;
    assign pop  = d_valid_o && d_ready_i;

    // ---------------------------------------------------------------------
    // Request decode and check
    // ---------------------------------------------------------------------
    assign idx    = a_address_i[2 +: IdxW];
    assign is_get = (a_opcode_i == OpGet);
    assign is_put = (a_opcode_i == OpPutFull) || (a_opcode_i == OpPutPartial);

    always_comb begin
        align_ok = 1'b0;
        case (a_size_i)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = !a_address_i[0];
            2'd2:    align_ok = (a_address_i[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    // Bits above the index field must be zero; the index compare also
    // covers a Depth that is not a power of two.
    assign range_ok = (a_address_i[31:2+IdxW] == '0)
                   && ({1'b0, idx} < (IdxW+1)'(Depth));

    assign req_err = !(is_get || is_put) || !align_ok || !range_ok;

    always_comb begin
        rsp_new        = '0;
        rsp_new.opcode = is_put ? OpAccessAck : OpAccessAckData;
        rsp_new.size   = a_size_i;
        rsp_new.source = a_source_i;
        rsp_new.error  = req_err;
        if (req_err) begin
            rsp_new.data = is_put ? 32'h0 : 32'hFFFF_FFFF;
        end else if (is_get) begin
            rsp_new.data = mem_q[idx];
        end
    end

    // ---------------------------------------------------------------------
    // Memory write with byte lanes
    // ---------------------------------------------------------------------
    always_comb begin
        for (int w = 0; w < Depth; w++) begin
            mem_d[w] = mem_q[w];
        end
        if (push && is_put && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask_i[b]) begin
                    mem_d[idx][8*b +: 8] = a_data_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------------
    always_comb begin
        for (int e = 0; e < RspDepth; e++) begin
            fifo_d[e] = fifo_q[e];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            fifo_d[wr_ptr_q] = rsp_new;
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < Depth; w++) begin
                mem_q[w] <= '0;
            end
            for (int e = 0; e < RspDepth; e++) begin
                fifo_q[e] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int w = 0; w < Depth; w++) begin
                mem_q[w] <= mem_d[w];
            end
            for (int e = 0; e < RspDepth; e++) begin
                fifo_q[e] <= fifo_d[e];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------------------------------------------------------------
    // D channel: head entry, forced to zero when nothing is pending so that
    // stale entries never show on the bus.
    // ---------------------------------------------------------------------
    assign head = fifo_q[rd_ptr_q];

    assign d_opcode_o = d_valid_o ? head.opcode : '0;
    assign d_size_o   = d_valid_o ? head.size   : '0;
    assign d_source_o = d_valid_o ? head.source : '0;
    assign d_data_o   = d_valid_o ? head.data   : '0;
    assign d_error_o  = d_valid_o ? head.error  : 1'b0;
    assign d_param_o  = '0;
    assign d_sink_o   = 1'b0;

endmodule

// File: doc/tlul_mem_responder.md
Name: tlul_mem_responder

Overview:
- TL-UL device-side responder. Accepts A-channel requests from a host and returns D-channel responses.
- Backed by a small flop-based word memory.
- Used as a synthesizable device endpoint in block-level benches and as a simple scratch RAM behind crossbars.
- Buffers responses in an internal FIFO so the host can pipeline up to RspDepth outstanding requests.

Parameters:
- Depth, 16, number of 32-bit words; word index = a_address[2 +: $clog2(Depth)]
- RspDepth, 2, response FIFO entries (max outstanding requests), >=1
- SourceW, 8, width of a_source/d_source

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- a_valid_i  in  1  request valid
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- a_param_i  in  3  ignored
- a_size_i  in  2  log2 bytes
- a_source_i  in  SourceW  request ID
- a_address_i  in  32  byte address
- a_mask_i  in  4  byte lane enables
- a_data_i  in  32  write data
- a_ready_o  out  1  request accepted when a_valid_i & a_ready_o
- d_valid_o  out  1  response valid
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData
- d_param_o  out  3  always 0
- d_size_o  out  2  echo of a_size_i
- d_source_o  out  SourceW  echo of a_source_i
- d_sink_o  out  1  always 0
- d_data_o  out  32  read data, or 0 for writes
- d_error_o  out  1  error response
- d_ready_i  in  1  response consumed when d_valid_o & d_ready_i

Behaviour:
- Reset (rst_i=1, async): FIFO emptied, count=0, all memory words cleared to 0. Outputs: a_ready_o=0 while rst_i=1, 1 after release; d_valid_o=0; all d_* fields 0.
- a_ready_o = !rst_i && (count < RspDepth).
  - Combinational only on registered count; no path from d_ready_i or a_valid_i.
  - When full, a_ready_o=0 even if d_ready_i=1 in the same cycle.
- Request check at acceptance. Error if any of:
  - opcode not in {0,1,4}
  - a_size_i > 2
  - a_address_i not aligned to 2^a_size_i
  - address bits above the index field nonzero (address beyond Depth*4)
- Get, no error: enqueue AccessAckData with d_data = mem[idx] sampled at the accept edge, d_error=0.
- Put (0 or 1), no error: at the accept edge, write byte lane i of mem[idx] where a_mask_i[i]=1. Enqueue AccessAck, d_data=0, d_error=0. Mask is used as given for both Put opcodes; mask all-zero writes nothing but still acks.
- Error: no memory write. Enqueue opcode AccessAckData for Get or for an unsupported opcode, AccessAck for Put. d_data=32'hFFFF_FFFF for AccessAckData, 0 otherwise; d_error=1.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data. Same-cycle ordering is impossible (one request per cycle).
- Latency: request accepted at edge N -> d_valid_o=1 from cycle N+1 (registered FIFO head). No same-cycle response.
- FIFO:
  - In-order, circular pointers wrap modulo RspDepth.
  - d_* outputs driven from the head entry and held stable while d_valid_o=1 && d_ready_i=0.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - count increments on accept-only, decrements on pop-only.
- d_valid_o = (count != 0).
- Reset asserted mid-transaction: pending responses discarded, no response is issued for them, memory cleared. Protocol restarts cleanly after release.

Test Plan:
- PutFull addr 0x8, mask 4'hF, data 32'hDEAD_BEEF, source 3; then Get addr 0x8 source 5 -> AccessAck src 3 err 0, then AccessAckData src 5 data 32'hDEAD_BEEF, each d_valid_o one cycle after accept.
- PutPartial addr 0x8 mask 4'b0010 data 32'h0000_AA00 over 32'hDEAD_BEEF -> subsequent Get returns 32'hDEAD_AAEF.
- Hold d_ready_i=0, issue 3 back-to-back Gets with RspDepth=2 -> a_ready_o falls after the 2nd accept. Head response stays stable. Raise d_ready_i -> 3rd accepted one cycle after the first pop. Order and sources preserved.
- Get addr 0x40 (Depth=16) -> d_error_o=1, data 32'hFFFF_FFFF. Get addr 0x2 size 2 -> error. Opcode 3 -> error. Put addr 0x44 -> AccessAck err 1, memory unchanged.
- Continuous traffic with d_ready_i=1 -> one accept and one response per cycle, count steady at 1, pointers wrap correctly over 10+ transactions.
- Assert rst_i with 2 responses pending -> d_valid_o=0 and a_ready_o=0 immediately. After release, a Get of a previously written word returns 0 and no stale response appears.
